// File: rtl/ram_write_ctrl_if.sv
// rtl/ram_write_ctrl_if.sv - camera byte stream in, line-buffer RAM write port out
interface ram_write_ctrl_if #(
  parameter int AW = 7
);
  logic          VSYNC;
  logic          Href;
  logic          pix_stb;
  logic [7:0]    data_in;
  logic [11:0]   wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [1:0]    wr_slot;
  logic          row_done;
  logic          ovf;

  modport master (
    output VSYNC, Href, pix_stb, data_in,
    input  wr_en, wr_addr, wr_data, wr_slot, row_done, ovf
  );

  modport slave (
    input  VSYNC, Href, pix_stb, data_in,
    output wr_en, wr_addr, wr_data, wr_slot, row_done, ovf
  );
endinterface

// File: rtl/ram_write_ctrl.sv
// rtl/ram_write_ctrl.sv - luma capture into 4 rotating row slots x 3 column-interleaved banks
module ram_write_ctrl #(
  parameter int ROW_LEN = 160,
  parameter int AW      = 7,
  parameter int Y_FIRST = 1
) (
  input logic            clk,
  input logic            rst,
  ram_write_ctrl_if.slave bus
);
  localparam int   CW         = $clog2(ROW_LEN + 1);
  localparam logic LUMA_PHASE = (Y_FIRST == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, WAIT_ROW, CAPTURE, ROW_END} state_t;

  state_t        state, state_n;
  logic          vsync_d, href_d;
  logic [CW-1:0] col, col_n;
  logic [1:0]    bank, bank_n;
  logic [AW-1:0] addr, addr_n;
  logic          phase, phase_n;
  logic [1:0]    slot_n;
  logic          ovf_n;
  logic [11:0]   wr_en_n;
  logic [AW-1:0] wr_addr_n;
  logic [7:0]    wr_data_n;
  logic          row_done_c;
  logic [3:0]    wr_idx;

  wire vsync_rise = bus.VSYNC & ~vsync_d;
  wire vsync_fall = ~bus.VSYNC & vsync_d;
  wire href_rise  = bus.Href & ~href_d;
  wire href_fall  = ~bus.Href & href_d;

  assign wr_idx       = {2'b00, bus.wr_slot} * 4'd3 + {2'b00, bank};
  assign bus.row_done = row_done_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      col         <= '0;
      bank        <= '0;
      addr        <= '0;
      phase       <= 1'b0;
      bus.wr_slot <= '0;
      bus.ovf     <= 1'b0;
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else begin
      state       <= state_n;
      vsync_d     <= bus.VSYNC;
      href_d      <= bus.Href;
      col         <= col_n;
      bank        <= bank_n;
      addr        <= addr_n;
      phase       <= phase_n;
      bus.wr_slot <= slot_n;
      bus.ovf     <= ovf_n;
      bus.wr_en   <= wr_en_n;
      bus.wr_addr <= wr_addr_n;
      bus.wr_data <= wr_data_n;
    end
  end

  always_comb begin
    state_n    = state;
    col_n      = col;
    bank_n     = bank;
    addr_n     = addr;
    phase_n    = phase;
    slot_n     = bus.wr_slot;
    ovf_n      = bus.ovf;
    wr_en_n    = '0;
    wr_addr_n  = bus.wr_addr;
    wr_data_n  = bus.wr_data;
    row_done_c = 1'b0;

    // A frame restart discards whatever row is in flight.
    if (vsync_rise) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (vsync_fall) begin
            state_n = WAIT_ROW;
            slot_n  = '0;
            ovf_n   = 1'b0;
          end
        end
        WAIT_ROW: begin
          if (href_rise) begin
            state_n = CAPTURE;
            col_n   = '0;
            bank_n  = '0;
            addr_n  = '0;
            phase_n = 1'b0;
          end
        end
        CAPTURE: begin
          if (href_fall) begin
            state_n = ROW_END;
          end else if (bus.pix_stb && bus.Href) begin
            phase_n = ~phase;
            if (phase == LUMA_PHASE) begin
              if (col < CW'(ROW_LEN)) begin
                wr_en_n   = 12'b1 << wr_idx;
                wr_addr_n = addr;
                wr_data_n = bus.data_in;
                col_n     = col + CW'(1);
                // Bank 2 -> 0 moves to the next address triple.
                if (bank == 2'd2) begin
                  bank_n = '0;
                  addr_n = addr + AW'(1);
                end else begin
                  bank_n = bank + 2'd1;
                end
              end else begin
                ovf_n = 1'b1;
              end
            end
          end
        end
        ROW_END: begin
          state_n = WAIT_ROW;
          if (col != '0) begin
            row_done_c = 1'b1;
            slot_n     = bus.wr_slot + 2'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_write_ctrl.sv
// tb/tb_ram_write_ctrl.sv - scoreboard bench for ram_write_ctrl
module tb_ram_write_ctrl;
  localparam int ROW_LEN = 160;
  localparam int AW      = 7;

  typedef struct {
    logic [11:0]   en;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_slot   = 0;
  wr_t  wq[$];
  int   rq[$];
  wr_t  mon_e;

  ram_write_ctrl_if #(.AW(AW)) bus ();

  ram_write_ctrl #(.ROW_LEN(ROW_LEN), .AW(AW), .Y_FIRST(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.pix_stb = 1'b1;
    bus.data_in = b;
    tick();
    bus.pix_stb = 1'b0;
    tick();
  endtask

  task automatic frame_start();
    bus.VSYNC = 1'b1;
    repeat (2) tick();
    bus.VSYNC = 1'b0;
    repeat (2) tick();
    exp_slot = 0;
  endtask

  // Streams npix pixels (luma first); when close=1, drops Href and expects row_done.
  task automatic send_row(input int npix, input logic [7:0] base, input bit close);
    wr_t w;
    logic [7:0] y;
    bus.Href = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < npix; c++) begin
      y = base + 8'(c);
      if (c < ROW_LEN) begin
        w.en   = 12'b1 << (3 * exp_slot + (c % 3));
        w.addr = AW'(c / 3);
        w.data = y;
        wq.push_back(w);
      end
      send_byte(y);
      send_byte(8'hA5 ^ 8'(c));
    end
    if (close) begin
      bus.Href = 1'b0;
      if (npix > 0) begin
        rq.push_back(exp_slot);
        exp_slot = (exp_slot + 1) % 4;
      end
      repeat (3) tick();
    end
  endtask

  always @(negedge clk) begin
    if (bus.wr_en != '0) begin
      check("onehot", $countones(bus.wr_en), 1);
      if (wq.size() == 0) begin
        check("unexpected_wr", {20'd0, bus.wr_en}, 0);
      end else begin
        mon_e = wq.pop_front();
        check("wr_en", {20'd0, bus.wr_en}, {20'd0, mon_e.en});
        check("wr_addr", {25'd0, bus.wr_addr}, {25'd0, mon_e.addr});
        check("wr_data", {24'd0, bus.wr_data}, {24'd0, mon_e.data});
      end
    end
    if (bus.row_done) begin
      if (rq.size() == 0) check("unexpected_row_done", {31'd0, bus.row_done}, 0);
      else                check("row_done_slot", {30'd0, bus.wr_slot}, rq.pop_front());
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, {20'd0, bus.wr_en}, 0);
    check({tag, "_wr_addr"}, {25'd0, bus.wr_addr}, 0);
    check({tag, "_wr_data"}, {24'd0, bus.wr_data}, 0);
    check({tag, "_wr_slot"}, {30'd0, bus.wr_slot}, 0);
    check({tag, "_row_done"}, {31'd0, bus.row_done}, 0);
    check({tag, "_ovf"}, {31'd0, bus.ovf}, 0);
  endtask

  initial begin
    bus.VSYNC   = 1'b0;
    bus.Href    = 1'b0;
    bus.pix_stb = 1'b0;
    bus.data_in = '0;
    repeat (3) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Full 160-pixel row, Y = col
    frame_start();
    send_row(160, 8'd0, 1'b1);
    check("slot_after_row1", {30'd0, bus.wr_slot}, exp_slot);
    check("ovf_exact_len", {31'd0, bus.ovf}, 0);
    check("hold_addr", {25'd0, bus.wr_addr}, 53);
    check("hold_data", {24'd0, bus.wr_data}, 159);

    // Four more rows walk the slots 1,2,3 and back to 0
    for (int r = 0; r < 4; r++) begin
      send_row(12, 8'(8'h40 + 8'(16 * r)), 1'b1);
      check("slot_rotate", {30'd0, bus.wr_slot}, exp_slot);
    end

    // Overlong row: only ROW_LEN writes, sticky ovf
    send_row(170, 8'h10, 1'b1);
    check("ovf_set", {31'd0, bus.ovf}, 1);
    check("slot_after_ovf", {30'd0, bus.wr_slot}, exp_slot);

    // VSYNC rises mid-row at col 50
    send_row(50, 8'h80, 1'b0);
    bus.VSYNC = 1'b1;
    repeat (3) tick();
    bus.Href = 1'b0;
    repeat (2) tick();
    check("slot_after_abort", {30'd0, bus.wr_slot}, exp_slot);
    check("ovf_kept_in_blank", {31'd0, bus.ovf}, 1);
    bus.VSYNC = 1'b0;
    repeat (2) tick();
    exp_slot = 0;
    check("slot_new_frame", {30'd0, bus.wr_slot}, 0);
    check("ovf_cleared", {31'd0, bus.ovf}, 0);

    // Href pulse with no strobes
    bus.Href = 1'b1;
    repeat (5) tick();
    bus.Href = 1'b0;
    repeat (3) tick();
    check("slot_empty_line", {30'd0, bus.wr_slot}, exp_slot);

    send_row(9, 8'hC0, 1'b1);
    check("slot_before_rst", {30'd0, bus.wr_slot}, exp_slot);

    // Reset mid-row with a luma strobe in the same cycle
    send_row(30, 8'h20, 1'b0);
    rst         = 1'b1;
    bus.pix_stb = 1'b1;
    bus.data_in = 8'h77;
    tick();
    bus.pix_stb = 1'b0;
    check_zero("midrow_rst");
    rst = 1'b0;
    tick();
    exp_slot = 0;
    for (int c = 0; c < 10; c++) send_byte(8'(c));
    bus.Href = 1'b0;
    repeat (2) tick();
    bus.Href = 1'b1;
    repeat (2) tick();
    for (int c = 0; c < 10; c++) send_byte(8'(c));
    bus.Href = 1'b0;
    repeat (3) tick();
    check("no_wr_after_rst", {20'd0, bus.wr_en}, 0);

    frame_start();
    send_row(7, 8'hE0, 1'b1);
    check("slot_after_recover", {30'd0, bus.wr_slot}, exp_slot);

    repeat (4) tick();
    check("wr_queue_empty", wq.size(), 0);
    check("row_done_queue_empty", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
